// File: rtl/bigmul_unit_ps.sv
// Product-scanning big-integer multiplier: column-wise accumulation of up to PARALLEL limb
// products per cycle, with operand/result memories reached through explicit write/read ports.
module bigmul_unit_ps #(
  parameter int LIMB_W    = 64,
  parameter int NUM_LIMBS = 64,
  parameter int PARALLEL  = 25,
  localparam int AW = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1,
  localparam int RW = $clog2(2 * NUM_LIMBS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic              i_wr_en,
  input  logic              i_wr_sel,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [LIMB_W-1:0] i_wr_data,
  input  logic [RW-1:0]     i_rd_addr,
  output logic [LIMB_W-1:0] o_rd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [63:0]       o_cycles_out
);

  localparam int KW    = RW + 1;
  localparam int PW    = $clog2(NUM_LIMBS + PARALLEL + 1);
  localparam int ACC_W = 2 * LIMB_W + $clog2(NUM_LIMBS) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_FINAL,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_mode;
  logic [KW-1:0]       r_k;
  logic [PW-1:0]       r_pidx;
  logic [ACC_W-1:0]    r_acc;
  logic [63:0]         r_cycles;
  logic [LIMB_W-1:0]   r_rd_data;
  logic [LIMB_W-1:0]   r_a   [NUM_LIMBS];
  logic [LIMB_W-1:0]   r_b   [NUM_LIMBS];
  logic [LIMB_W-1:0]   r_res [2*NUM_LIMBS];

  logic [KW-1:0]       w_i_lo;
  logic [KW-1:0]       w_i_hi;
  logic [KW-1:0]       w_terms;
  logic                w_last_chunk;
  logic                w_last_col;
  logic [ACC_W-1:0]    w_sum;
  logic [ACC_W-1:0]    w_acc_next;
  logic                w_wr_ok;
  logic                w_busy;
  logic                w_done;

  // Column geometry: pairs (i, k-i) with i in [i_lo, i_hi]
  always_comb begin
    w_i_lo       = (r_k > KW'(NUM_LIMBS - 1)) ? (r_k - KW'(NUM_LIMBS - 1)) : '0;
    w_i_hi       = (r_k < KW'(NUM_LIMBS)) ? r_k : KW'(NUM_LIMBS - 1);
    w_terms      = w_i_hi - w_i_lo + KW'(1);
    w_last_chunk = (32'(r_pidx) + 32'(PARALLEL)) >= 32'(w_terms);
    w_last_col   = (r_k == (r_mode ? KW'(NUM_LIMBS - 1) : KW'(2 * NUM_LIMBS - 2)));
  end

  always_comb begin : p_products
    logic [2*LIMB_W-1:0] v_prod;
    logic [AW-1:0]       v_ai;
    logic [AW-1:0]       v_bj;
    int unsigned         v_idx;
    w_sum  = '0;
    v_prod = '0;
    v_ai   = '0;
    v_bj   = '0;
    v_idx  = 0;
    for (int m = 0; m < PARALLEL; m++) begin
      v_idx = 32'(r_pidx) + 32'(m);
      if (v_idx < 32'(w_terms)) begin
        v_ai   = AW'(32'(w_i_lo) + v_idx);
        v_bj   = AW'(32'(r_k) - 32'(w_i_lo) - v_idx);
        v_prod = {{LIMB_W{1'b0}}, r_a[v_ai]} * {{LIMB_W{1'b0}}, r_b[v_bj]};
        w_sum  = w_sum + ACC_W'(v_prod);
      end
    end
  end

  assign w_acc_next = r_acc + w_sum;

  // A write racing a start is dropped so the launched operation sees a stable operand set
  assign w_wr_ok = i_wr_en && ((r_state == S_DONE) || ((r_state == S_IDLE) && !i_start));

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) w_state_next = S_COMPUTE;
      end
      S_COMPUTE: begin
        w_busy = 1'b1;
        if (w_last_chunk && w_last_col) w_state_next = r_mode ? S_DONE : S_FINAL;
      end
      S_FINAL: begin
        w_busy       = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_mode    <= 1'b0;
      r_k       <= '0;
      r_pidx    <= '0;
      r_cycles  <= '0;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_next;
      r_rd_data <= (r_mode && (i_rd_addr >= RW'(NUM_LIMBS))) ? '0 : r_res[i_rd_addr];
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode   <= i_mode;
            r_k      <= '0;
            r_pidx   <= '0;
            r_cycles <= '0;
          end
        end
        S_COMPUTE: begin
          r_cycles <= r_cycles + 64'd1;
          if (w_last_chunk) begin
            r_k    <= r_k + KW'(1);
            r_pidx <= '0;
          end else begin
            r_pidx <= r_pidx + PW'(PARALLEL);
          end
        end
        S_FINAL: r_cycles <= r_cycles + 64'd1;
        default: ;
      endcase
    end
  end

  // Accumulator carries the column remainder into the next column
  always_ff @(posedge i_clk) begin
    if ((r_state == S_IDLE) && i_start) begin
      r_acc <= '0;
    end else if (r_state == S_COMPUTE) begin
      r_acc <= w_last_chunk ? (w_acc_next >> LIMB_W) : w_acc_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (w_wr_ok) begin
        if (i_wr_sel) r_b[i_wr_addr] <= i_wr_data;
        else          r_a[i_wr_addr] <= i_wr_data;
      end
      if ((r_state == S_COMPUTE) && w_last_chunk) r_res[RW'(r_k)] <= w_acc_next[LIMB_W-1:0];
      if (r_state == S_FINAL) r_res[RW'(2 * NUM_LIMBS - 1)] <= r_acc[LIMB_W-1:0];
    end
  end

  assign o_rd_data    = r_rd_data;
  assign o_busy       = w_busy;
  assign o_done       = w_done;
  assign o_cycles_out = r_cycles;

endmodule

// File: doc/bigmul_unit_ps.md
# bigmul_unit_ps

Parametrised product-scanning big-integer multiplier, the successor to the fixed 64-bit-limb CSA multiplier. Limb width, limb count and partial products per cycle are generic. Operands are loaded and results read through explicit memory ports rather than hierarchical access. A truncated low-half mode and an exact cycle count make it suitable for the simulator's BIGMUL custom-instruction timing model.

## Interface
- LIMB_W, 64, bits per limb
- NUM_LIMBS, 64, limbs per operand (N); result holds 2N limbs
- PARALLEL, 25, limb products accumulated per cycle (P ≥ 1)
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle start request; honoured only in IDLE
- mode  in  1  sampled with start: 0 = full 2N-limb product, 1 = low N limbs only
- wr_en  in  1  operand write strobe; ignored unless IDLE or DONE
- wr_sel  in  1  0 = A, 1 = B
- wr_addr  in  clog2(N)  limb index
- wr_data  in  LIMB_W  limb value
- rd_addr  in  clog2(2N)  result limb index
- rd_data  out  LIMB_W  R[rd_addr], registered
- busy  out  1  high in COMPUTE and FINAL
- done  out  1  one-cycle pulse in DONE
- cycles_out  out  64  cycle count of the last operation, held until the next start

## Operation
- Storage:
  - A[0..N-1] and B[0..N-1] are written only via the write port.
  - R[0..2N-1] is written only by the engine.
  - None of these are cleared by reset.
- States: IDLE → COMPUTE → FINAL → DONE → IDLE. The low-half mode skips FINAL, going COMPUTE → DONE.
- IDLE with start=1:
  - latch mode;
  - clear the accumulator, column k and the pair index;
  - clear cycles_out;
  - go to COMPUTE.
- COMPUTE handles column k, which holds all pairs (i,j) with i+j=k and 0≤i,j<N, t_k = min(k, 2N−2−k)+1 terms.
  - Each cycle adds up to P products A[i]*B[j] to acc, taking i in ascending order.
  - In the cycle that adds the column's last chunk, R[k] is written with the low LIMB_W bits of the updated acc, acc is shifted right by LIMB_W, and k is incremented.
- Column range: full mode covers k = 0..2N−2, then FINAL. Low mode covers k = 0..N−1, then DONE.
- FINAL (one cycle): R[2N−1] = acc[LIMB_W−1:0].
- acc width is 2·LIMB_W + clog2(N) + 1 bits. This must never overflow. The result is exact modulo 2^(2N·LIMB_W) for full mode and modulo 2^(N·LIMB_W) for low mode.
- Low mode: R[N..2N−1] are left unmodified. rd_data returns 0 for rd_addr ≥ N until the next start, based on the latched mode.
- cycles_out increments once per COMPUTE or FINAL cycle. Final values:
  - full mode: Σ_{k=0}^{2N−2} ceil(t_k/P) + 1
  - low mode: Σ_{k=0}^{N−1} ceil(t_k/P)
- The following are ignored with no side effects:
  - start while busy or in DONE;
  - wr_en while busy.
- rd_data during busy returns current storage. Values are final only once done has pulsed.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state goes to IDLE;
  - busy=0, done=0, cycles_out=0, rd_data=0.
  - This applies mid-operation too: the operation is abandoned and R is left partially written.
- start sampled high at edge e0: busy=1 from e0 through the last COMPUTE/FINAL cycle.
- done=1 for exactly one cycle after the last busy cycle. busy=0 during that cycle. cycles_out is already final when done is high.
- Start to done latency is cycles_out + 1 edges.
- The earliest next start is the cycle after done, i.e. back in IDLE.
- Operand writes take effect at the edge they are sampled. A write in the same cycle as start is not seen by that operation.
- rd_data has one-cycle latency: rd_addr sampled at edge e appears after e.

## Test plan
- N=4, P=2, LIMB_W=64, all A and B limbs 0xFFFFFFFFFFFFFFFF, mode=0. Required:
  - cycles_out=11;
  - R[0]=1, R[1..3]=0;
  - R[4]=0xFFFFFFFFFFFFFFFE, R[5..7]=0xFFFFFFFFFFFFFFFF;
  - done pulses exactly once, 12 edges after start.
- Same operands, mode=1. Required: cycles_out=6, R[0]=1, R[1..3]=0, and reads of R[4..7] return 0.
- N=4, P=2, A=[3,0,0,0], B=[0,5,0,7] (limb 0 first), full mode. Required: R=[0,15,0,21,0,0,0,0] and cycles_out=11.
- P=1, N=4, random operands, compared against a 512-bit reference model. Required: cycles_out=17 and exact match. Repeat with P=25 for 64 limbs of 0x7FFFFFFFFFFFFFFF and match the model.
- Run a second start and a write to A[0] mid-COMPUTE. Required: both are ignored, the result is unchanged, and there is a single done pulse.
- Drop rst_n for one cycle mid-COMPUTE. Required:
  - busy, done and cycles_out become 0 the next cycle and done never pulses;
  - a fresh start then yields the correct result and count.
